fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_ADDSUB, default 2, meaning settle cycles allowed for add/sub (range 1..31).
REQ-002 SHALL have parameter LAT_MUL, default 3, meaning settle cycles allowed for multiply (range 1..31).
REQ-003 SHALL have parameter LAT_DIV, default 12, meaning settle cycles allowed for divide (range 1..31).
REQ-004 SHALL have parameter LAT_SQRT, default 16, meaning settle cycles allowed for square root (range 1..31).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n, in that order.
REQ-006 SHALL have these ports, one per line, as name direction width meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_op  in  5  FPU opcode.
- req_sel  in  1  add/sub select, 1 = subtract.
- req_rs1  in  32  operand A.
- req_rs2  in  32  operand B.
- req_rd  in  5  destination tag.
- fpu_rs1  out  32  operand A to the FPU datapath, registered.
- fpu_rs2  out  32  operand B to the FPU datapath, registered.
- fpu_control  out  5  opcode to the FPU datapath, registered.
- fpu_sel  out  1  add/sub select to the FPU datapath, registered.
- fpu_result  in  32  combinational FPU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  captured result.
- rsp_rd  out  5  destination tag, echoed.
- rsp_illegal  out  1  opcode was unsupported.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 SHALL use opcodes 00000/00001 = ADDSUB, 00010 = MUL, 00011 = DIV, 01011 = SQRT; every other opcode is illegal.
REQ-008 SHALL implement three states, IDLE, EXEC and RESP; req_ready = (state == IDLE) && !flush.
REQ-009 SHALL accept a request (handshake at edge k) into the following state: legal opcode -> EXEC; illegal opcode -> RESP with rsp_illegal=1 and rsp_data=0.
REQ-010 SHALL perform these actions at acceptance:
- register req_rs1/req_rs2/req_op/req_sel onto the fpu_* outputs;
- capture req_rd;
- load a 5-bit down-counter with LAT_x-1 for the accepted opcode.
REQ-011 SHALL hold fpu_rs1, fpu_rs2, fpu_control and fpu_sel stable from acceptance until the next acceptance.
REQ-012 SHALL decrement the counter once per EXEC cycle; in the EXEC cycle where the count is 0, it SHALL capture fpu_result into rsp_data and enter RESP.
REQ-013 SHALL assert rsp_valid first in cycle k+LAT_x+1 for a legal opcode and in cycle k+1 for an illegal opcode.
REQ-014 SHALL hold rsp_valid, rsp_data, rsp_rd and rsp_illegal stable in RESP until rsp_valid && rsp_ready, then return to IDLE.
REQ-015 SHALL not overlap operations: a new request can be accepted no earlier than the cycle after the response handshake.
REQ-016 SHALL, when flush is high, go to IDLE at the next edge from any state and drop the in-flight result; rsp_valid is low in the following cycle and no request is accepted while flush is high.
REQ-017 SHALL give flush priority over a simultaneous rsp_ready handshake; the response counts as consumed.
REQ-018 SHALL not consume any opcode bits other than req_op[4:0].

Reset
REQ-019 SHALL, while rst_n is low, asynchronously force state=IDLE, counter=0, all fpu_* outputs=0, rsp_data=0, rsp_rd=0, rsp_illegal=0, rsp_valid=0 and busy=0.
REQ-020 SHALL discard any operation in progress when reset is asserted mid-operation; after deassertion, req_ready rises in the first cycle with flush low.

Configuration
REQ-021 SHALL, with macro FPU_SQRT_EN defined, treat 01011 as legal with latency LAT_SQRT.
REQ-022 SHALL, without FPU_SQRT_EN, treat 01011 as illegal per REQ-009 and omit the LAT_SQRT counter-load path.

Structure
REQ-023 SHALL place the opcode constants, the state enumeration and the default latency constants in the shared package fpu_pkg.
REQ-024 SHALL implement opcode decode (legal flag plus latency selection) in one sub-module, fpu_lat_decode, with the FSM and registers in the top level.

Verification
REQ-025 SHALL cover a MUL of 0x40000000 by 0x40400000 accepted at edge 0 with rsp_ready=1 -> rsp_valid in cycle 4, rsp_data=0x40C00000, rsp_rd echoed.
REQ-026 SHALL cover a SUB (op 00001, sel=1) of 0x40400000 and 0x3F800000 with rsp_ready held 0 for 5 cycles -> rsp_data=0x40000000 held stable and req_ready=0 throughout.
REQ-027 SHALL cover op 00101 -> rsp_valid in cycle 1, rsp_illegal=1, rsp_data=0.
REQ-028 SHALL cover a DIV accepted with flush pulsed in EXEC cycle 5 -> IDLE, no rsp_valid, and the next request accepted on the following cycle.
REQ-029 SHALL cover a SQRT of 0x41800000 -> 0x40800000 after 17 cycles with FPU_SQRT_EN defined, and rsp_illegal=1 after 1 cycle without it.
REQ-030 SHALL cover rst_n asserted mid-DIV -> all outputs zero immediately, asynchronously.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcode encodings,
// controller state enumeration and default per-operation settle latencies.
package fpu_pkg;

  // Opcode encodings on req_op[4:0]
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_SQRT = 5'b01011;

  // Default settle cycles per operation class (legal range 1..31)
  localparam int DEF_LAT_ADDSUB = 2;
  localparam int DEF_LAT_MUL    = 3;
  localparam int DEF_LAT_DIV    = 12;
  localparam int DEF_LAT_SQRT   = 16;

  // Issue controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_lat_decode.sv
// Opcode decode for the FPU issue controller: flags legal opcodes and
// selects the settle-counter load value (latency minus one).
// Optional feature macro: FPU_SQRT_EN makes opcode 01011 (SQRT) legal.
module fpu_lat_decode
  import fpu_pkg::*;
#(
  parameter int LAT_ADDSUB = DEF_LAT_ADDSUB,
  parameter int LAT_MUL    = DEF_LAT_MUL,
  parameter int LAT_DIV    = DEF_LAT_DIV,
  parameter int LAT_SQRT   = DEF_LAT_SQRT
) (
  input  logic [4:0] i_op,
  output logic       o_legal,
  output logic [4:0] o_lat_m1
);

  // Reject latencies the 5-bit down-counter cannot represent
  if (LAT_ADDSUB < 1 || LAT_ADDSUB > 31) begin : g_bad_lat_addsub
    $error("LAT_ADDSUB must be in 1..31");
  end
  if (LAT_MUL < 1 || LAT_MUL > 31) begin : g_bad_lat_mul
    $error("LAT_MUL must be in 1..31");
  end
  if (LAT_DIV < 1 || LAT_DIV > 31) begin : g_bad_lat_div
    $error("LAT_DIV must be in 1..31");
  end
  if (LAT_SQRT < 1 || LAT_SQRT > 31) begin : g_bad_lat_sqrt
    $error("LAT_SQRT must be in 1..31");
  end

  // Decode opcode into legal flag and counter load value
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    o_legal  = 1'b0;
    o_lat_m1 = '0;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_legal  = 1'b1;
        o_lat_m1 = 5'(LAT_ADDSUB - 1);
      end
      OP_MUL: begin
        o_legal  = 1'b1;
        o_lat_m1 = 5'(LAT_MUL - 1);
      end
      OP_DIV: begin
        o_legal  = 1'b1;
        o_lat_m1 = 5'(LAT_DIV - 1);
      end
`ifdef FPU_SQRT_EN
      OP_SQRT: begin
        o_legal  = 1'b1;
        o_lat_m1 = 5'(LAT_SQRT - 1);
      end
`endif
      default: begin
        o_legal  = 1'b0;
        o_lat_m1 = '0;
      end
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one request at a time, drives registered
// operands/opcode to a combinational FPU datapath, waits the per-op settle
// time, captures the result and holds it until the response handshake.
// Optional feature macro: FPU_SQRT_EN (SQRT opcode support, see decode).
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_ADDSUB = DEF_LAT_ADDSUB,
  parameter int LAT_MUL    = DEF_LAT_MUL,
  parameter int LAT_DIV    = DEF_LAT_DIV,
  parameter int LAT_SQRT   = DEF_LAT_SQRT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic        req_sel,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [4:0]  fpu_control,
  output logic        fpu_sel,
  input  logic [31:0] fpu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_illegal,
  output logic        busy
);

  state_e      r_state;
  state_e      w_next_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_fpu_rs1;
  logic [31:0] r_fpu_rs2;
  logic [4:0]  r_fpu_control;
  logic        r_fpu_sel;
  logic [31:0] r_rsp_data;
  logic [4:0]  r_rsp_rd;
  logic        r_rsp_illegal;

  logic        w_legal;
  logic [4:0]  w_lat_m1;
  logic        w_accept;
  logic        w_cnt_zero;

  fpu_lat_decode #(
    .LAT_ADDSUB (LAT_ADDSUB),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV),
    .LAT_SQRT   (LAT_SQRT)
  ) u_lat_decode (
    .i_op     (req_op),
    .o_legal  (w_legal),
    .o_lat_m1 (w_lat_m1)
  );

  assign req_ready  = (r_state == ST_IDLE) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign w_cnt_zero = (r_cnt == 5'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flush overrides everything, including a response handshake
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_next_state = w_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: if (w_cnt_zero) w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready)  w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
    if (flush) w_next_state = ST_IDLE;
  end

  // Issue registers, settle counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath flop is reset because the outputs must read zero during reset.
    if (!rst_n) begin
      r_cnt         <= '0;
      r_fpu_rs1     <= '0;
      r_fpu_rs2     <= '0;
      r_fpu_control <= '0;
      r_fpu_sel     <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_rd      <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (w_accept) begin
      r_fpu_rs1     <= req_rs1;
      r_fpu_rs2     <= req_rs2;
      r_fpu_control <= req_op;
      r_fpu_sel     <= req_sel;
      r_rsp_rd      <= req_rd;
      r_cnt         <= w_lat_m1;
      r_rsp_illegal <= !w_legal;
      r_rsp_data    <= '0;
    end else if (r_state == ST_EXEC && !flush) begin
      if (w_cnt_zero) begin
        r_rsp_data <= fpu_result;
      end else begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  assign fpu_rs1     = r_fpu_rs1;
  assign fpu_rs2     = r_fpu_rs2;
  assign fpu_control = r_fpu_control;
  assign fpu_sel     = r_fpu_sel;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_illegal = r_rsp_illegal;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with default latencies.
// A stub FPU returns hand-computed IEEE-754 results for the vectors used.
// Build with +define+FPU_SQRT_EN to exercise the SQRT path.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic        req_sel = 1'b0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_result, rsp_data;
  logic [4:0]  fpu_control, rsp_rd;
  logic        fpu_sel, rsp_valid, rsp_illegal, busy;
  logic        rsp_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  fpu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_sel     (req_sel),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd      (req_rd),
    .fpu_rs1     (fpu_rs1),
    .fpu_rs2     (fpu_rs2),
    .fpu_control (fpu_control),
    .fpu_sel     (fpu_sel),
    .fpu_result  (fpu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_rd      (rsp_rd),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Stub datapath: known answers for the operand pairs used below
  function automatic logic [31:0] fpu_stub(input logic [4:0] c, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
    if (c == 5'b00001 && s && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000; // 3-1
    if (c == 5'b00000 && !s && a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000; // 1+1
    if (c == 5'b00010 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;       // 2*3
    if (c == 5'b00011 && a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;       // 6/2
    if (c == 5'b01011 && a == 32'h4180_0000) return 32'h4080_0000;                            // sqrt 16
    return 32'hDEAD_BEEF;
  endfunction

  assign fpu_result = fpu_stub(fpu_control, fpu_sel, fpu_rs1, fpu_rs2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE, wait for the response, then
  // hold it 'hold' cycles before completing the handshake.
  task automatic run_op(input string tag, input logic [4:0] op, input logic sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int exp_cyc, input logic [31:0] exp_data,
                        input logic exp_ill, input int hold);
    int n;
    check({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_sel = sel;
    req_rs1 = a; req_rs2 = b; req_rd = rd;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      if (rsp_valid) break;
    end
    check({tag, ".cyc"}, 32'(n), 32'(exp_cyc));
    check({tag, ".data"}, rsp_data, exp_data);
    check({tag, ".rd"}, 32'(rsp_rd), 32'(rd));
    check({tag, ".ill"}, 32'(rsp_illegal), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_v"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_d"}, rsp_data, exp_data);
      check({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".done_v"}, 32'(rsp_valid), 32'd0);
    check({tag, ".done_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.fpu_rs1", fpu_rs1, 32'd0);
    check("rst.data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 2*3, ready held high: response in cycle 4
    run_op("mul", OP_MUL, 1'b0, 32'h4000_0000, 32'h4040_0000, 5'd7, 4, 32'h40C0_0000, 1'b0, 0);
    check("mul.held_rs1", fpu_rs1, 32'h4000_0000);

    // SUB 3-1 with response back-pressured for 5 cycles
    run_op("sub", OP_SUB, 1'b1, 32'h4040_0000, 32'h3F80_0000, 5'd12, 3, 32'h4000_0000, 1'b0, 5);
    check("sub.held_sel", 32'(fpu_sel), 32'd1);
    check("sub.held_ctl", 32'(fpu_control), 32'(OP_SUB));

    // Illegal opcode: response next cycle, data cleared
    run_op("ill", 5'b00101, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1, 32'd0, 1'b1, 0);

    // ADD 1+1 and full DIV 6/2
    run_op("add", OP_ADD, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd1, 3, 32'h4000_0000, 1'b0, 0);
    run_op("div", OP_DIV, 1'b0, 32'h40C0_0000, 32'h4000_0000, 5'd30, 13, 32'h4040_0000, 1'b0, 1);

`ifdef FPU_SQRT_EN
    run_op("sqrt", OP_SQRT, 1'b0, 32'h4180_0000, 32'd0, 5'd9, 17, 32'h4080_0000, 1'b0, 0);
`else
    run_op("sqrt", OP_SQRT, 1'b0, 32'h4180_0000, 32'd0, 5'd9, 1, 32'd0, 1'b1, 0);
`endif

    // DIV flushed in EXEC cycle 5, next request accepted in cycle 6
    req_valid = 1'b1; req_op = OP_DIV; req_sel = 1'b0;
    req_rs1 = 32'h40C0_0000; req_rs2 = 32'h4000_0000; req_rd = 5'd17;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush.exec_busy", 32'(busy), 32'd1);
    check("flush.rdy_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush.idle_v", 32'(rsp_valid), 32'd0);
    check("flush.idle_busy", 32'(busy), 32'd0);
    run_op("post_flush", OP_MUL, 1'b0, 32'h4000_0000, 32'h4040_0000, 5'd2, 4, 32'h40C0_0000, 1'b0, 0);

    // Flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_op = OP_MUL;
    #1 check("flush_idle.rdy", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_idle.busy", 32'(busy), 32'd0);

    // Flush together with response handshake
    req_valid = 1'b1; req_op = 5'b00111; req_rd = 5'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("flush_rsp.v", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_rsp.after_v", 32'(rsp_valid), 32'd0);
    check("flush_rsp.after_rdy", 32'(req_ready), 32'd1);

    // Asynchronous reset mid-DIV
    req_valid = 1'b1; req_op = OP_DIV; req_sel = 1'b1;
    req_rs1 = 32'h40C0_0000; req_rs2 = 32'h4000_0000; req_rd = 5'd21;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("arst.pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.valid", 32'(rsp_valid), 32'd0);
    check("arst.rs1", fpu_rs1, 32'd0);
    check("arst.rs2", fpu_rs2, 32'd0);
    check("arst.ctl", 32'(fpu_control), 32'd0);
    check("arst.sel", 32'(fpu_sel), 32'd0);
    check("arst.rd", 32'(rsp_rd), 32'd0);
    check("arst.data", rsp_data, 32'd0);
    check("arst.ill", 32'(rsp_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", OP_ADD, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd4, 3, 32'h4000_0000, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
